// File: rtl/ofs_pkg.sv
// Shared types and constants for the ofs_pipe_bank output-register bank.
// Optional feature macro used by the bank: OFS_GSR_EN (global set/reset sampling).
package ofs_pkg;

  localparam int OFS_CNT_W = 16;
  localparam logic [OFS_CNT_W-1:0] OFS_CNT_MAX = 16'hFFFF;
  localparam int OFS_MAX_W = 64;
  localparam int OFS_MAX_STAGES = 8;

  localparam string OFS_GSR_ENABLED = "ENABLED";
  localparam string OFS_GSR_DISABLED = "DISABLED";

  // One retiming stage at the widest supported data width.
  typedef struct packed {
    logic [OFS_MAX_W-1:0] data;
    logic                 t;
    logic                 v;
  } ofs_stage_t;

  // True when the width/depth parameters are inside the supported range.
  function automatic bit ofs_params_ok(input int width, input int stages);
    return (width >= 1) && (width <= OFS_MAX_W) &&
           (stages >= 1) && (stages <= OFS_MAX_STAGES);
  endfunction

endpackage

// File: rtl/ofs_stage.sv
// One {data, t, v} retiming stage: synchronous clear to {INIT, 1, 0},
// shift on enable, hold otherwise.
// With OFS_GSR_EN defined the stage also clears asynchronously on gsr_n low.
module ofs_stage
  import ofs_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             sclk,
  input  logic             cd,
  input  logic             sp,
`ifdef OFS_GSR_EN
  input  logic             gsr_n,
`endif
  input  logic [WIDTH-1:0] d,
  input  logic             td,
  input  logic             dv,
  output logic [WIDTH-1:0] q,
  output logic             t,
  output logic             qv
);

`ifdef OFS_GSR_EN
  // Stage register: global reset asynchronously, clear beats shift, else hold.
  always_ff @(posedge sclk or negedge gsr_n) begin
    if (!gsr_n) begin
      q  <= INIT;
      t  <= 1'b1;
      qv <= 1'b0;
    end else if (cd) begin
      q  <= INIT;
      t  <= 1'b1;
      qv <= 1'b0;
    end else if (sp) begin
      q  <= d;
      t  <= td;
      qv <= dv;
    end
  end
`else
  // Stage register: clear beats shift, else hold.
  always_ff @(posedge sclk) begin
    if (cd) begin
      q  <= INIT;
      t  <= 1'b1;
      qv <= 1'b0;
    end else if (sp) begin
      q  <= d;
      t  <= td;
      qv <= dv;
    end
  end
`endif

endmodule

// File: rtl/ofs_pipe_bank.sv
// Multi-bit, multi-stage registered output path toward the pad buffers.
// Data and tristate control move together through STAGES ofs_stage registers
// under a common enable; OCNT counts valid words reaching the last stage.
// Optional macro OFS_GSR_EN: sample the device GSR/PUR nets as an
// asynchronous clear with a 2-flop synchronised release of shifting.
module ofs_pipe_bank
  import ofs_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter int               STAGES = 2,
  parameter logic [WIDTH-1:0] INIT   = '0,
  parameter string            GSR    = "ENABLED"
) (
  input  logic                 SCLK,
  input  logic                 CD,
  input  logic                 SP,
  input  logic [WIDTH-1:0]     D,
  input  logic                 TD,
  input  logic                 DV,
  output logic [WIDTH-1:0]     Q,
  output logic                 T,
  output logic                 QV,
  output logic [OFS_CNT_W-1:0] OCNT
);

  if (!ofs_params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("ofs_pipe_bank: WIDTH must be 1..64 and STAGES 1..8");
  end
  if ((GSR != OFS_GSR_ENABLED) && (GSR != OFS_GSR_DISABLED)) begin : g_bad_gsr
    $error("ofs_pipe_bank: GSR must be \"ENABLED\" or \"DISABLED\"");
  end

  // Index 0 is the input word, index i+1 is the output of stage i.
  logic [STAGES:0][WIDTH-1:0] data_s;
  logic [STAGES:0]            t_s;
  logic [STAGES:0]            v_s;
  logic                       shift_en_s;
  logic                       cnt_inc_s;
  logic [OFS_CNT_W-1:0]       ocnt_r;
  logic [OFS_CNT_W-1:0]       ocnt_nxt_s;

  assign data_s[0] = D;
  assign t_s[0]    = TD;
  assign v_s[0]    = DV;

`ifdef OFS_GSR_EN
  logic       gsr_n_s;
  logic [1:0] gsr_sync_r;

  if (GSR == OFS_GSR_ENABLED) begin : g_gsr_on
    assign gsr_n_s = GSR_INST.GSRNET & PUR_INST.PURNET;
  end else begin : g_gsr_off
    assign gsr_n_s = PUR_INST.PURNET;
  end

  // Release synchroniser: shifting resumes two edges after the global net rises.
  always_ff @(posedge SCLK or negedge gsr_n_s) begin
    if (!gsr_n_s) begin
      gsr_sync_r <= 2'b00;
    end else begin
      gsr_sync_r <= {gsr_sync_r[0], 1'b1};
    end
  end

  assign shift_en_s = SP & gsr_sync_r[1];
`else
  assign shift_en_s = SP;
`endif

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    ofs_stage #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_stage (
      .sclk  (SCLK),
      .cd    (CD),
      .sp    (shift_en_s),
`ifdef OFS_GSR_EN
      .gsr_n (gsr_n_s),
`endif
      .d     (data_s[i]),
      .td    (t_s[i]),
      .dv    (v_s[i]),
      .q     (data_s[i+1]),
      .t     (t_s[i+1]),
      .qv    (v_s[i+1])
    );
  end

  // A count happens on the edge that moves a valid word into the last stage.
  assign cnt_inc_s = shift_en_s & v_s[STAGES-1];

  // Saturating increment of the delivered-word counter.
  always_comb begin
    ocnt_nxt_s = ocnt_r;
    if (cnt_inc_s && (ocnt_r != OFS_CNT_MAX)) begin
      ocnt_nxt_s = ocnt_r + 16'd1;
    end else begin
      ocnt_nxt_s = ocnt_r;
    end
  end

`ifdef OFS_GSR_EN
  // Delivered-word counter with global and synchronous clear.
  always_ff @(posedge SCLK or negedge gsr_n_s) begin
    if (!gsr_n_s) begin
      ocnt_r <= 16'd0;
    end else if (CD) begin
      ocnt_r <= 16'd0;
    end else begin
      ocnt_r <= ocnt_nxt_s;
    end
  end
`else
  // Delivered-word counter with synchronous clear.
  always_ff @(posedge SCLK) begin
    if (CD) begin
      ocnt_r <= 16'd0;
    end else begin
      ocnt_r <= ocnt_nxt_s;
    end
  end
`endif

  assign Q    = data_s[STAGES];
  assign T    = t_s[STAGES];
  assign QV   = v_s[STAGES];
  assign OCNT = ocnt_r;

endmodule

// File: tb/tb_ofs_pipe_bank.sv
// Self-checking bench for ofs_pipe_bank (WIDTH=8, STAGES=2, INIT=8'hA5).
// Reference: the list of words accepted since the last clear; the output is
// the word accepted STAGES enables ago, the counter tallies valid ones.
module tb_ofs_pipe_bank;

  localparam int         W      = 8;
  localparam int         STAGES = 2;
  localparam logic [7:0] INIT_V = 8'hA5;

  logic         SCLK;
  logic         CD;
  logic         SP;
  logic [W-1:0] D;
  logic         TD;
  logic         DV;
  logic [W-1:0] Q;
  logic         T;
  logic         QV;
  logic [15:0]  OCNT;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [W-1:0] d;
    logic         t;
    logic         v;
  } word_t;

  word_t       hist[$];
  logic [15:0] mcnt;

  ofs_pipe_bank #(
    .WIDTH  (W),
    .STAGES (STAGES),
    .INIT   (INIT_V),
    .GSR    ("ENABLED")
  ) dut (
    .SCLK (SCLK),
    .CD   (CD),
    .SP   (SP),
    .D    (D),
    .TD   (TD),
    .DV   (DV),
    .Q    (Q),
    .T    (T),
    .QV   (QV),
    .OCNT (OCNT)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  // Reference update for one rising edge.
  task automatic model_edge(input logic cd, input logic sp, input logic [W-1:0] d,
                            input logic td, input logic dv);
    word_t w;
    if (cd) begin
      hist.delete();
      mcnt = 16'd0;
    end else if (sp) begin
      w.d = d;
      w.t = td;
      w.v = dv;
      hist.push_back(w);
      if (hist.size() > STAGES) void'(hist.pop_front());
      if ((hist.size() == STAGES) && hist[0].v && (mcnt != 16'hFFFF)) mcnt = mcnt + 16'd1;
    end
  endtask

  function automatic logic [W-1:0] exp_q();
    if (hist.size() == STAGES) return hist[0].d;
    else return INIT_V;
  endfunction

  function automatic logic exp_t();
    if (hist.size() == STAGES) return hist[0].t;
    else return 1'b1;
  endfunction

  function automatic logic exp_qv();
    if (hist.size() == STAGES) return hist[0].v;
    else return 1'b0;
  endfunction

  // Drive one cycle from a falling edge, update the model, return at the next falling edge.
  task automatic step(input logic cd, input logic sp, input logic [W-1:0] d,
                      input logic td, input logic dv);
    CD = cd; SP = sp; D = d; TD = td; DV = dv;
    @(posedge SCLK);
    model_edge(cd, sp, d, td, dv);
    @(negedge SCLK);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'($urandom), 1'b0, 1'b1);
    n_chk++; if (Q !== 8'hA5) begin n_fail++; $display("FAIL reset_q: got %h expected a5", Q); end
    n_chk++; if (T !== 1'b1) begin n_fail++; $display("FAIL reset_t: got %b expected 1", T); end
    n_chk++; if (QV !== 1'b0) begin n_fail++; $display("FAIL reset_qv: got %b expected 0", QV); end
    n_chk++; if (OCNT !== 16'd0) begin n_fail++; $display("FAIL reset_ocnt: got %0d expected 0", OCNT); end
  endtask

  task automatic test_latency();
    step(1'b0, 1'b1, 8'h11, 1'b0, 1'b1);
    n_chk++; if (QV !== 1'b0 || Q !== 8'hA5) begin n_fail++; $display("FAIL lat_edge1: got q=%h qv=%b expected q=a5 qv=0", Q, QV); end
    step(1'b0, 1'b1, 8'h22, 1'b0, 1'b1);
    n_chk++; if (Q !== 8'h11 || QV !== 1'b1 || T !== 1'b0) begin n_fail++; $display("FAIL lat_edge2: got q=%h qv=%b t=%b expected q=11 qv=1 t=0", Q, QV, T); end
    n_chk++; if (OCNT !== 16'd1) begin n_fail++; $display("FAIL lat_cnt1: got %0d expected 1", OCNT); end
    step(1'b0, 1'b1, 8'h33, 1'b0, 1'b1);
    n_chk++; if (Q !== 8'h22) begin n_fail++; $display("FAIL lat_edge3: got %h expected 22", Q); end
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    n_chk++; if (Q !== 8'h33 || QV !== 1'b1) begin n_fail++; $display("FAIL lat_edge4: got q=%h qv=%b expected q=33 qv=1", Q, QV); end
    n_chk++; if (OCNT !== 16'd3) begin n_fail++; $display("FAIL lat_cnt3: got %0d expected 3", OCNT); end
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    n_chk++; if (QV !== 1'b0 || T !== 1'b1 || OCNT !== 16'd3) begin n_fail++; $display("FAIL lat_drain: got qv=%b t=%b ocnt=%0d expected qv=0 t=1 ocnt=3", QV, T, OCNT); end
  endtask

  task automatic test_stall();
    logic [W-1:0] fq;
    logic         fqv;
    logic [15:0]  fcnt;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, W'(8'h40 + i), 1'b0, 1'b1);
    fq = exp_q(); fqv = exp_qv(); fcnt = mcnt;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, W'($urandom), 1'($urandom), 1'b1);
      n_chk++; if (Q !== fq || QV !== fqv || OCNT !== fcnt) begin n_fail++; $display("FAIL stall_frozen: got q=%h qv=%b ocnt=%0d expected q=%h qv=%b ocnt=%0d", Q, QV, OCNT, fq, fqv, fcnt); end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, W'(8'h50 + i), 1'b0, (i < 2) ? 1'b1 : 1'b0);
      n_chk++; if (Q !== exp_q() || QV !== exp_qv() || OCNT !== mcnt) begin n_fail++; $display("FAIL stall_resume: got q=%h qv=%b ocnt=%0d expected q=%h qv=%b ocnt=%0d", Q, QV, OCNT, exp_q(), exp_qv(), mcnt); end
    end
  endtask

  task automatic test_clear_priority();
    step(1'b0, 1'b1, 8'hC1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'hC2, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'hC3, 1'b0, 1'b1);
    n_chk++; if (Q !== 8'hA5 || T !== 1'b1 || QV !== 1'b0) begin n_fail++; $display("FAIL clr_out: got q=%h t=%b qv=%b expected q=a5 t=1 qv=0", Q, T, QV); end
    n_chk++; if (OCNT !== 16'd0) begin n_fail++; $display("FAIL clr_ocnt: got %0d expected 0", OCNT); end
    step(1'b0, 1'b1, 8'h5A, 1'b0, 1'b1);
    n_chk++; if (QV !== 1'b0) begin n_fail++; $display("FAIL clr_first_lat: got qv=%b expected 0", QV); end
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    n_chk++; if (Q !== 8'h5A || QV !== 1'b1 || OCNT !== 16'd1) begin n_fail++; $display("FAIL clr_first_word: got q=%h qv=%b ocnt=%0d expected q=5a qv=1 ocnt=1", Q, QV, OCNT); end
  endtask

  task automatic test_sp_toggle();
    for (int i = 0; i < 40; i++) begin
      step(1'b0, i[0] ? 1'b0 : 1'b1, W'(i), 1'($urandom), 1'b1);
      n_chk++; if (Q !== exp_q() || T !== exp_t() || QV !== exp_qv() || OCNT !== mcnt) begin n_fail++; $display("FAIL toggle_c%0d: got q=%h t=%b qv=%b ocnt=%0d expected q=%h t=%b qv=%b ocnt=%0d", i, Q, T, QV, OCNT, exp_q(), exp_t(), exp_qv(), mcnt); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           W'($urandom), 1'($urandom), 1'($urandom));
      n_chk++; if (Q !== exp_q() || T !== exp_t() || QV !== exp_qv() || OCNT !== mcnt) begin n_fail++; $display("FAIL random_c%0d: got q=%h t=%b qv=%b ocnt=%0d expected q=%h t=%b qv=%b ocnt=%0d", i, Q, T, QV, OCNT, exp_q(), exp_t(), exp_qv(), mcnt); end
    end
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 65534 + STAGES - 1; i++) step(1'b0, 1'b1, W'(i), 1'b0, 1'b1);
    n_chk++; if (OCNT !== 16'hFFFE || OCNT !== mcnt) begin n_fail++; $display("FAIL sat_pre: got %h expected fffe (model %h)", OCNT, mcnt); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, W'($urandom), 1'b0, 1'b1);
      n_chk++; if (OCNT !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold%0d: got %h expected ffff", i, OCNT); end
    end
  endtask

  initial begin
    CD = 1'b1; SP = 1'b0; D = 8'h00; TD = 1'b0; DV = 1'b0;
    mcnt = 16'd0;
    @(negedge SCLK);
    test_reset();
    test_latency();
    test_stall();
    test_clear_priority();
    test_sp_toggle();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
